// File: rtl/trivium_stream_pkg.sv
// Shared types and constants for the Trivium keystream generator.
package trivium_stream_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WARMUP = 2'd1,
      ST_GEN    = 2'd2
   } triv_state_t;

   localparam int TRIV_KEY_W   = 80;
   localparam int TRIV_IV_W    = 80;
   localparam int TRIV_STATE_W = 288;

   // Bit i-1 of the returned vector holds Trivium cell s(i).
   function automatic logic [TRIV_STATE_W-1:0] triv_load(input logic [TRIV_KEY_W+TRIV_IV_W-1:0] seed);
      logic [TRIV_STATE_W-1:0] s;
      s                  = '0;
      s[TRIV_KEY_W-1:0]  = seed[TRIV_KEY_W-1:0];
      s[93 +: TRIV_IV_W] = seed[TRIV_KEY_W +: TRIV_IV_W];
      s[287:285]         = 3'b111;
      return s;
   endfunction

endpackage

// File: rtl/trivium_stream_round.sv
// One combinational Trivium step: 288-bit state in, next state and keystream bit out.
module trivium_round
   import trivium_stream_pkg::*;
(
   input  logic [TRIV_STATE_W-1:0] i_state,
   output logic [TRIV_STATE_W-1:0] o_state,
   output logic                    o_z
);

   logic w_t1, w_t2, w_t3;
   logic w_n1, w_n2, w_n3;

   assign w_t1 = i_state[65]  ^ i_state[92];
   assign w_t2 = i_state[161] ^ i_state[176];
   assign w_t3 = i_state[242] ^ i_state[287];
   assign o_z  = w_t1 ^ w_t2 ^ w_t3;

   assign w_n1 = w_t1 ^ (i_state[90]  & i_state[91])  ^ i_state[170];
   assign w_n2 = w_t2 ^ (i_state[174] & i_state[175]) ^ i_state[263];
   assign w_n3 = w_t3 ^ (i_state[285] & i_state[286]) ^ i_state[68];

   // Three shift registers: s1..s93, s94..s177, s178..s288 each take a feedback bit at the bottom.
   assign o_state = {i_state[286:177], w_n2, i_state[175:93], w_n1, i_state[91:0], w_n3};

endmodule

// File: rtl/trivium_stream.sv
// Trivium keystream generator: seed load, warm-up, then words over a valid/ready port.
module trivium_stream
   import trivium_stream_pkg::*;
#(
   parameter int OUT_WIDTH     = 64,
   parameter int UNROLL        = 8,
   parameter int WARMUP_ROUNDS = 1152,
   parameter int RESEED_WORDS  = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  seed_valid_i,
   input  logic [159:0]          seed_i,
   output logic                  seed_ready_o,
   input  logic                  force_reseed_i,
   output logic                  triv_valid_o,
   output logic [OUT_WIDTH-1:0]  triv_port_o,
   input  logic                  triv_ready_i,
   output logic                  keyed_o,
   output logic [1:0]            dbg_state_o
);

   // Handshake: a word moves on an edge where triv_valid_o && triv_ready_i; the word
   // is held stable while valid && !ready. A seed is taken when seed_valid_i && seed_ready_o.

   localparam int WARM_CLKS = WARMUP_ROUNDS / UNROLL;
   localparam int FILL_N    = OUT_WIDTH / UNROLL;
   localparam int RCNT_W    = $clog2(WARM_CLKS + 1);
   localparam int FILL_W    = $clog2(FILL_N + 1);
   localparam int WCNT_W    = (RESEED_WORDS == 0) ? 1 : $clog2(RESEED_WORDS + 1);
   localparam logic [WCNT_W-1:0] WCNT_LAST = (RESEED_WORDS == 0) ? '0 : WCNT_W'(RESEED_WORDS - 1);

   triv_state_t              r_fsm;
   logic [TRIV_STATE_W-1:0]  r_state;
   logic [OUT_WIDTH-1:0]     r_acc;
   logic [FILL_W-1:0]        r_fill;
   logic [RCNT_W-1:0]        r_rcnt;
   logic [WCNT_W-1:0]        r_wcnt;
   logic                     r_valid;
   logic [OUT_WIDTH-1:0]     r_port;

   logic [TRIV_STATE_W-1:0]  w_chain [0:UNROLL];
   logic [UNROLL-1:0]        w_z;
   logic                     w_full, w_can_xfer, w_stall, w_complete, w_xfer;
   logic [FILL_W-1:0]        w_base;
   logic [OUT_WIDTH-1:0]     w_word, w_xfer_word;

   assign w_chain[0] = r_state;

   generate
      for (genvar g = 0; g < UNROLL; g++) begin : g_round
         trivium_round u_round (
            .i_state (w_chain[g]),
            .o_state (w_chain[g+1]),
            .o_z     (w_z[g])
         );
      end
   endgenerate

   // A full accumulator with the output register still held freezes the cipher.
   always_comb begin
      w_full      = (r_fill == FILL_W'(FILL_N));
      w_can_xfer  = !r_valid || triv_ready_i;
      w_stall     = w_full && !w_can_xfer;
      w_base      = w_full ? '0 : r_fill;
      w_complete  = (w_base == FILL_W'(FILL_N - 1));
      w_word      = (w_base == '0) ? '0 : r_acc;
      for (int k = 0; k < FILL_N; k++) begin
         if (w_base == FILL_W'(k)) w_word[k*UNROLL +: UNROLL] = w_z;
      end
      w_xfer      = (r_fsm == ST_GEN) && !w_stall && (w_full || (w_complete && w_can_xfer));
      w_xfer_word = w_full ? r_acc : w_word;
   end

   always_ff @(posedge clk) begin
      if (rst || force_reseed_i) begin
         r_fsm   <= ST_IDLE;
         r_state <= '0;
         r_acc   <= '0;
         r_fill  <= '0;
         r_rcnt  <= '0;
         r_wcnt  <= '0;
         r_valid <= 1'b0;
         r_port  <= '0;
      end else begin
         if (w_xfer) begin
            r_port  <= w_xfer_word;
            r_valid <= 1'b1;
         end else if (triv_ready_i) begin
            r_valid <= 1'b0;
         end

         case (r_fsm)
            ST_IDLE: begin
               if (seed_valid_i) begin
                  r_state <= triv_load(seed_i);
                  r_rcnt  <= '0;
                  r_fsm   <= ST_WARMUP;
               end
            end
            ST_WARMUP: begin
               r_state <= w_chain[UNROLL];
               if (r_rcnt == RCNT_W'(WARM_CLKS - 1)) begin
                  r_rcnt <= '0;
                  r_fsm  <= ST_GEN;
               end else begin
                  r_rcnt <= r_rcnt + 1'b1;
               end
            end
            ST_GEN: begin
               if (!w_stall) begin
                  r_state <= w_chain[UNROLL];
                  r_acc   <= w_word;
                  if (!w_complete)
                     r_fill <= w_base + 1'b1;
                  else if (w_full || !w_can_xfer)
                     r_fill <= FILL_W'(FILL_N);
                  else
                     r_fill <= '0;
               end
               if (w_xfer && (RESEED_WORDS != 0)) begin
                  if (r_wcnt == WCNT_LAST) begin
                     r_wcnt  <= '0;
                     r_fsm   <= ST_IDLE;
                     r_state <= '0;
                     r_acc   <= '0;
                     r_fill  <= '0;
                  end else begin
                     r_wcnt <= r_wcnt + 1'b1;
                  end
               end
            end
            default: r_fsm <= ST_IDLE;
         endcase
      end
   end

   assign seed_ready_o = (r_fsm == ST_IDLE);
   assign keyed_o      = (r_fsm == ST_WARMUP) || (r_fsm == ST_GEN);
   assign dbg_state_o  = r_fsm;
   assign triv_valid_o = r_valid;
   assign triv_port_o  = r_port;

endmodule
